// File: rtl/uart_sample_packer_if.sv
// rtl/uart_sample_packer_if.sv - UART byte stream in, sample FIFO write and status out
interface uart_sample_packer_if #(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH  = 24
);
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  i_rx_err;
    logic                  i_fifo_full;
    logic                  o_fifo_wr;
    logic [DATA_WIDTH-1:0] o_fifo_data;
    logic                  o_new_record;
    logic [CTR_WIDTH-1:0]  o_ctr;
    logic                  o_sync_err;
    logic                  o_overflow;

    modport master (
        output i_rx_data, i_rx_valid, i_rx_err, i_fifo_full,
        input  o_fifo_wr, o_fifo_data, o_new_record, o_ctr, o_sync_err, o_overflow
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_err, i_fifo_full,
        output o_fifo_wr, o_fifo_data, o_new_record, o_ctr, o_sync_err, o_overflow
    );
endinterface

// File: rtl/uart_sample_packer.sv
// rtl/uart_sample_packer.sv - reassembles two-byte UART frames into ECG sample FIFO writes
module uart_sample_packer #(
    parameter int DATA_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CTR_WIDTH      = 24
) (
    input logic                 i_clk,
    input logic                 i_rst,
    uart_sample_packer_if.slave bus
);
    localparam int HI_W  = DATA_WIDTH - 7;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, HAVE_HIGH} state_t;

    state_t                state_q, state_d;
    logic [HI_W-1:0]       hi_q, hi_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  new_rec_q, new_rec_d;
    logic [CTR_WIDTH-1:0]  ctr_q, ctr_d;
    logic                  sync_err_q, sync_err_d;
    logic                  ovf_q, ovf_d;

    logic is_marker, is_high, high_ok;

    assign is_marker = (bus.i_rx_data == 8'hFF);
    assign is_high   = bus.i_rx_data[7];
    // Any bit above the sample's upper field (including [6:4]) makes the high byte illegal
    assign high_ok   = ((bus.i_rx_data[6:0] >> HI_W) == 7'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            tmo_q      <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            new_rec_q  <= 1'b0;
            ctr_q      <= '0;
            sync_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            tmo_q      <= tmo_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            new_rec_q  <= new_rec_d;
            ctr_q      <= ctr_d;
            sync_err_q <= sync_err_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        tmo_d      = tmo_q;
        wr_d       = 1'b0;
        data_d     = data_q;
        new_rec_d  = 1'b0;
        ctr_d      = ctr_q;
        sync_err_d = 1'b0;
        ovf_d      = ovf_q;

        if (bus.i_rx_valid) begin
            if (bus.i_rx_err) begin
                sync_err_d = 1'b1;
                state_d    = IDLE;
            end else if (is_marker) begin
                new_rec_d = 1'b1;
                ctr_d     = '0;
                ovf_d     = 1'b0;
                state_d   = IDLE;
            end else if (is_high) begin
                if (!high_ok) begin
                    sync_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    // A second high byte supersedes the first and restarts the timeout
                    sync_err_d = (state_q == HAVE_HIGH);
                    state_d    = HAVE_HIGH;
                    hi_d       = bus.i_rx_data[HI_W-1:0];
                    tmo_d      = '0;
                end
            end else if (state_q == IDLE) begin
                sync_err_d = 1'b1;
            end else begin
                state_d = IDLE;
                if (!bus.i_fifo_full) begin
                    wr_d   = 1'b1;
                    data_d = {hi_q, bus.i_rx_data[6:0]};
                    ctr_d  = ctr_q + CTR_WIDTH'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end else if (state_q == HAVE_HIGH) begin
            if (tmo_q == TMO_LAST) begin
                state_d    = IDLE;
                sync_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign bus.o_fifo_wr    = wr_q;
    assign bus.o_fifo_data  = data_q;
    assign bus.o_new_record = new_rec_q;
    assign bus.o_ctr        = ctr_q;
    assign bus.o_sync_err   = sync_err_q;
    assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_uart_sample_packer.sv
// tb/tb_uart_sample_packer.sv - self-checking bench for uart_sample_packer
module tb_uart_sample_packer;
    localparam int DW = 11;
    localparam int T  = 16;
    localparam int CW = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    uart_sample_packer_if #(.DATA_WIDTH(DW), .CTR_WIDTH(CW)) bus ();

    uart_sample_packer #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T),
        .CTR_WIDTH     (CW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame state as plain integers, timeout judged from cycle timestamps
    bit     m_have;
    int     m_hi;
    longint m_hi_cyc;
    longint cyc;
    int     m_ctr;
    bit     m_ovf;
    int     m_data;
    int     obs_writes;
    int     obs_sync;

    task automatic model_reset();
        m_have = 0; m_hi = 0; m_hi_cyc = 0; m_ctr = 0; m_ovf = 0; m_data = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit e, input bit f);
        bit ew, enr, ese;
        ew = 0; enr = 0; ese = 0;
        bus.i_rx_valid  = v;
        bus.i_rx_data   = d;
        bus.i_rx_err    = e;
        bus.i_fifo_full = f;
        cyc++;
        if (v) begin
            if (e) begin
                ese = 1; m_have = 0;
            end else if (d == 8'hFF) begin
                enr = 1; m_ctr = 0; m_ovf = 0; m_have = 0;
            end else if (d >= 8'h80) begin
                if ((int'(d) - 128) >= (1 << (DW - 7))) begin
                    ese = 1; m_have = 0;
                end else begin
                    ese = m_have; m_have = 1; m_hi = int'(d) - 128; m_hi_cyc = cyc;
                end
            end else if (!m_have) begin
                ese = 1;
            end else begin
                m_have = 0;
                if (!f) begin
                    ew = 1;
                    m_data = m_hi * 128 + int'(d);
                    m_ctr = (m_ctr + 1) % (1 << CW);
                end else begin
                    m_ovf = 1;
                end
            end
        end else if (m_have && (cyc - m_hi_cyc) == T) begin
            m_have = 0; ese = 1;
        end
        @(posedge i_clk);
        #1;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_err    = 1'b0;
        bus.i_fifo_full = 1'b0;
        check("fifo_wr",    bus.o_fifo_wr,    ew);
        check("fifo_data",  bus.o_fifo_data,  m_data);
        check("new_record", bus.o_new_record, enr);
        check("sync_err",   bus.o_sync_err,   ese);
        check("ctr",        bus.o_ctr,        m_ctr);
        check("overflow",   bus.o_overflow,   m_ovf);
        if (bus.o_fifo_wr)  obs_writes++;
        if (bus.o_sync_err) obs_sync++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    task automatic send_sample(input int code, input bit full);
        step(1, 8'(8'h80 | (code >> 7)), 0, 0);
        step(1, 8'(code & 127), 0, full);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        #2;
        check("rst_wr",   bus.o_fifo_wr,    0);
        check("rst_data", bus.o_fifo_data,  0);
        check("rst_nr",   bus.o_new_record, 0);
        check("rst_ctr",  bus.o_ctr,        0);
        check("rst_se",   bus.o_sync_err,   0);
        check("rst_ovf",  bus.o_overflow,   0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int w0, s0, r;
        bus.i_rx_data   = 8'h00;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_err    = 1'b0;
        bus.i_fifo_full = 1'b0;
        cyc = 0; obs_writes = 0; obs_sync = 0;
        #1;
        do_reset();

        step(1, 8'h85, 0, 0);
        step(1, 8'h2A, 0, 0);
        check("first_code", bus.o_fifo_data, 32'h2AA);

        w0 = obs_writes; s0 = obs_sync;
        for (int c = 0; c < 1000; c++) send_sample(c, 0);
        check("burst_writes", obs_writes - w0, 1000);
        check("burst_sync",   obs_sync - s0,   0);

        step(1, 8'h83, 0, 0);
        step(1, 8'h11, 0, 1);
        check("ovf_set", bus.o_overflow, 1);
        step(1, 8'hFF, 0, 0);
        check("ovf_clear", bus.o_overflow, 0);

        step(1, 8'h10, 0, 0);
        step(1, 8'h81, 0, 0);
        step(1, 8'h82, 0, 0);
        step(1, 8'h05, 0, 0);
        check("resync_code", bus.o_fifo_data, 32'h105);
        step(1, 8'hC1, 0, 0);
        step(1, 8'h05, 0, 0);

        step(1, 8'h81, 0, 0);
        idle(16);
        step(1, 8'h05, 0, 0);
        step(1, 8'h81, 0, 0);
        idle(15);
        step(1, 8'h05, 0, 0);

        step(1, 8'hFF, 0, 0);
        for (int c = 0; c < 17; c++) send_sample(c * 37, 0);
        step(1, 8'h81, 1, 0);
        step(1, 8'h05, 0, 0);

        step(1, 8'h81, 0, 0);
        do_reset();
        step(1, 8'h05, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      step(1, 8'(8'h80 | $urandom_range(0, 15)), 0, 0);
            else if (r < 65) step(1, 8'($urandom_range(0, 127)), 0, $urandom_range(0, 3) == 0);
            else if (r < 70) step(1, 8'hFF, 0, 0);
            else if (r < 77) step(1, 8'($urandom_range(128, 254)), 0, 0);
            else if (r < 82) step(1, 8'($urandom_range(0, 255)), 1, 0);
            else             idle($urandom_range(1, 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_sample_packer.md
# uart_sample_packer

Write-side companion of the ECG sample path for UART-sourced records. Takes the byte stream from the UART receiver, reassembles DATA_WIDTH-bit ECG sample codes from two-byte frames, and pushes them into the sample FIFO that the sample manager drains. Also detects the record-start marker, counts accepted samples and flags framing, sync, timeout and overflow faults. Samples are written as raw unsigned codes; signed conversion stays downstream.

## Interface
- DATA_WIDTH, 11, sample code width; legal range 8..11.
- TIMEOUT_CYCLES, 1_000_000, maximum i_clk cycles allowed between high and low byte; ≥2.
- CTR_WIDTH, 24, width of the written-sample counter.

- i_clk  in  1  single system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- i_rx_err  in  1  framing/parity error for the byte strobed with i_rx_valid.
- i_fifo_full  in  1  FIFO cannot accept a write this cycle.
- o_fifo_wr  out  1  FIFO write strobe, one cycle per sample.
- o_fifo_data  out  DATA_WIDTH  sample code, valid with o_fifo_wr.
- o_new_record  out  1  one-cycle pulse on record-start marker.
- o_ctr  out  CTR_WIDTH  samples written since reset/new record.
- o_sync_err  out  1  one-cycle pulse on any discarded byte or broken frame.
- o_overflow  out  1  sticky: at least one sample dropped on FIFO full.

## Operation
- Frame format: high byte = 1,0,0,0,s[DATA_WIDTH-1:7] (upper bits zero-padded into [3:0]); low byte = 0,s[6:0].
- Marker byte 0xFF = new record; legal in any state.
- States: IDLE (expect high byte), HAVE_HIGH (high bits latched, expect low byte).
- Byte classification on i_rx_valid, priority order:
  - i_rx_err=1: byte discarded, o_sync_err pulse, → IDLE.
  - 0xFF: o_new_record pulse, o_ctr←0, o_overflow←0, partial frame abandoned (no sync_err), → IDLE.
  - high byte with bits[6:4]≠000, or any unused upper pad bit set: discard, o_sync_err, → IDLE.
  - valid high byte: IDLE → HAVE_HIGH, latch bits; in HAVE_HIGH: replace latched bits, o_sync_err pulse, stay HAVE_HIGH, timeout restarts.
  - low byte in IDLE: discard, o_sync_err.
  - low byte in HAVE_HIGH: sample complete, → IDLE. If i_fifo_full=0 same cycle: write; else drop, o_overflow←1, o_ctr unchanged.
- Timeout counter runs only in HAVE_HIGH; cleared on entry. Reaching TIMEOUT_CYCLES without a low byte: → IDLE, o_sync_err pulse.
- o_ctr increments by 1 per write, wraps modulo 2^CTR_WIDTH to 0.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, timeout counter 0, latched bits 0.
- Low byte strobed at edge N → o_fifo_wr=1 and o_fifo_data valid for exactly cycle N+1; o_ctr shows incremented value from N+1.
- o_fifo_data holds last written value between writes.
- o_new_record, o_sync_err: registered, asserted cycle after causing byte, one cycle wide.
- i_fifo_full sampled only at low-byte acceptance edge; no retry, no buffering.
- Back-to-back bytes on consecutive cycles fully supported; sustained one sample per two cycles.
- Timeout fires on the edge where the counter equals TIMEOUT_CYCLES-1 with no byte; a byte arriving on that same edge wins and is processed normally.
- i_rst mid-frame: latched high bits lost; no write is emitted for the partial frame.

## Test plan
- Reset, then bytes 0x85,0x2A → one o_fifo_wr, o_fifo_data=0x2AA, o_ctr=1, no errors.
- 1000 back-to-back frames of incrementing codes 0x000..0x3E7 → 1000 writes in order, o_ctr=1000, sync_err never asserted.
- 0x83, i_fifo_full=1, 0x11 → no write, o_overflow=1, o_ctr unchanged; then 0xFF → o_new_record pulse, o_overflow=0, o_ctr=0.
- Low byte 0x10 in IDLE → o_sync_err pulse; 0x81,0x82,0x05 → one sync_err, write 0x105; 0xC1 → sync_err, no state change beyond IDLE.
- TIMEOUT_CYCLES=16: 0x81, no byte for 16 cycles → o_sync_err, IDLE; late 0x05 → second sync_err, no write.
- CTR_WIDTH=4: 17 valid frames → o_ctr wraps 15→0→1; 0x81 with i_rx_err=1 → sync_err, no write; i_rst asserted between 0x81 and 0x05 → no write, all outputs 0.
